// File: rtl/xdma_burst_receiver.sv
// Receives the AW/W bursts of one xDMA transfer, streams beats with byte addresses to a local sink,
// answers each burst with a B response and pulses done once the full transfer length has arrived.
module xdma_burst_receiver #(
    parameter int unsigned DataWidth = 512,
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned LenWidth  = 32,
    localparam int unsigned StrbWidth = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 recv_req_valid_i,
    output logic                 recv_req_ready_o,
    input  logic [LenWidth-1:0]  recv_len_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic [7:0]           aw_len_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic [DataWidth-1:0] w_data_i,
    input  logic [StrbWidth-1:0] w_strb_i,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic [StrbWidth-1:0] data_strb_o,
    output logic [AddrWidth-1:0] data_addr_o,
    output logic                 recv_done_o
);

    localparam int unsigned AddrLsb = $clog2(StrbWidth);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_AW, S_DATA, S_RESP, S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [LenWidth-1:0]  rem_q, rem_d;
    logic [8:0]           beats_q, beats_d;
    logic [8:0]           idx_q, idx_d;
    logic                 err_q, err_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic [AddrWidth-1:0] base_q, base_d;

    logic [8:0] aw_beats;
    logic       is_last;
    logic       beat_hs;

    assign aw_beats = {1'b0, aw_len_i} + 9'd1;
    assign is_last  = (idx_q == beats_q - 9'd1);
    assign beat_hs  = w_valid_i && data_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            beats_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            id_q    <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            beats_q <= beats_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            id_q    <= id_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        beats_d = beats_q;
        idx_d   = idx_q;
        err_d   = err_q;
        id_d    = id_q;
        base_d  = base_q;
        case (state_q)
            S_IDLE: begin
                if (recv_req_valid_i) begin
                    rem_d   = recv_len_i;
                    state_d = (recv_len_i == '0) ? S_DONE : S_WAIT_AW;
                end
            end
            S_WAIT_AW: begin
                if (aw_valid_i) begin
                    id_d    = aw_id_i;
                    base_d  = aw_addr_i;
                    beats_d = aw_beats;
                    idx_d   = '0;
                    err_d   = (LenWidth'(aw_beats) > rem_q);
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (beat_hs) begin
                    idx_d = idx_q + 9'd1;
                    // An overlong burst keeps draining beats but flags the error.
                    if (rem_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        rem_d = rem_q - LenWidth'(1);
                    end
                    if (w_last_i != is_last) begin
                        err_d = 1'b1;
                    end
                    if (is_last) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (b_ready_i) begin
                    state_d = (rem_q == '0) ? S_DONE : S_WAIT_AW;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        recv_req_ready_o = 1'b0;
        aw_ready_o       = 1'b0;
        w_ready_o        = 1'b0;
        data_valid_o     = 1'b0;
        b_valid_o        = 1'b0;
        b_id_o           = '0;
        b_resp_o         = 2'b00;
        recv_done_o      = 1'b0;
        data_o           = w_data_i;
        data_strb_o      = w_strb_i;
        data_addr_o      = base_q + AddrWidth'({idx_q, {AddrLsb{1'b0}}});
        case (state_q)
            S_IDLE:    recv_req_ready_o = 1'b1;
            S_WAIT_AW: aw_ready_o       = 1'b1;
            S_DATA: begin
                data_valid_o = w_valid_i;
                w_ready_o    = data_ready_i;
            end
            S_RESP: begin
                b_valid_o = 1'b1;
                b_id_o    = id_q;
                b_resp_o  = err_q ? 2'b10 : 2'b00;
            end
            S_DONE:  recv_done_o = 1'b1;
            default: ;
        endcase
        // Reset forces every output low, including the combinational pass-through.
        if (!rst_ni) begin
            recv_req_ready_o = 1'b0;
            aw_ready_o       = 1'b0;
            w_ready_o        = 1'b0;
            data_valid_o     = 1'b0;
            b_valid_o        = 1'b0;
            b_id_o           = '0;
            b_resp_o         = 2'b00;
            recv_done_o      = 1'b0;
            data_o           = '0;
            data_strb_o      = '0;
            data_addr_o      = '0;
        end
    end

endmodule

// File: tb/tb_xdma_burst_receiver.sv
// Directed bench for xdma_burst_receiver: multi-burst transfer, single beat, sink stall,
// misplaced last, overlong burst, zero length and reset mid-transfer.
module tb_xdma_burst_receiver;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         recv_req_valid;
    logic         recv_req_ready;
    logic [31:0]  recv_len;
    logic         aw_valid;
    logic         aw_ready;
    logic [3:0]   aw_id;
    logic [47:0]  aw_addr;
    logic [7:0]   aw_len;
    logic         w_valid;
    logic         w_ready;
    logic [511:0] w_data;
    logic [63:0]  w_strb;
    logic         w_last;
    logic         b_valid;
    logic         b_ready;
    logic [3:0]   b_id;
    logic [1:0]   b_resp;
    logic         data_valid;
    logic         data_ready;
    logic [511:0] data_o;
    logic [63:0]  data_strb;
    logic [47:0]  data_addr;
    logic         recv_done;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    xdma_burst_receiver dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .recv_req_valid_i (recv_req_valid),
        .recv_req_ready_o (recv_req_ready),
        .recv_len_i       (recv_len),
        .aw_valid_i       (aw_valid),
        .aw_ready_o       (aw_ready),
        .aw_id_i          (aw_id),
        .aw_addr_i        (aw_addr),
        .aw_len_i         (aw_len),
        .w_valid_i        (w_valid),
        .w_ready_o        (w_ready),
        .w_data_i         (w_data),
        .w_strb_i         (w_strb),
        .w_last_i         (w_last),
        .b_valid_o        (b_valid),
        .b_ready_i        (b_ready),
        .b_id_o           (b_id),
        .b_resp_o         (b_resp),
        .data_valid_o     (data_valid),
        .data_ready_i     (data_ready),
        .data_o           (data_o),
        .data_strb_o      (data_strb),
        .data_addr_o      (data_addr),
        .recv_done_o      (recv_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [31:0] len);
        recv_req_valid = 1'b1;
        recv_len       = len;
        #2;
        chk("req_rdy", 64'(recv_req_ready), 64'd1);
        next_cycle();
        recv_req_valid = 1'b0;
    endtask

    task automatic burst(input logic [3:0] id, input logic [47:0] base, input logic [7:0] awlen,
                         input int n, input int last_at, input int stall_at, input int stall_len,
                         input logic [1:0] resp, input bit fin);
        int k;
        int st;
        int cyc;
        aw_valid = 1'b1;
        aw_id    = id;
        aw_addr  = base;
        aw_len   = awlen;
        w_valid  = 1'b1;
        w_last   = 1'b0;
        data_ready = 1'b1;
        #2;
        chk("aw_rdy", 64'(aw_ready), 64'd1);
        chk("w_rdy_before_aw", 64'(w_ready), 64'd0);
        chk("vld_before_aw", 64'(data_valid), 64'd0);
        next_cycle();
        aw_valid = 1'b0;
        k = 0;
        st = 0;
        cyc = 0;
        while (k < n && cyc < 1000) begin
            w_valid    = 1'b1;
            w_data     = {8{64'(base) + 64'(k)}};
            w_strb     = ~64'(k);
            w_last     = (k == last_at);
            data_ready = !(k == stall_at && st < stall_len);
            #2;
            chk("data_vld", 64'(data_valid), 64'd1);
            if (data_ready) begin
                chk("w_rdy", 64'(w_ready), 64'd1);
                chk("addr", 64'(data_addr), 64'(base) + 64'(k) * 64);
                chk("data", data_o[63:0], 64'(base) + 64'(k));
                chk("strb", data_strb, ~64'(k));
            end else begin
                chk("stall_w_rdy", 64'(w_ready), 64'd0);
                st++;
            end
            next_cycle();
            if (data_ready) k++;
            cyc++;
        end
        chk("beats", 64'(k), 64'(n));
        w_valid = 1'b0;
        w_last  = 1'b0;
        b_ready = 1'b0;
        #2;
        chk("b_vld", 64'(b_valid), 64'd1);
        chk("b_id", 64'(b_id), 64'(id));
        chk("b_resp", 64'(b_resp), 64'(resp));
        chk("w_rdy_in_resp", 64'(w_ready), 64'd0);
        next_cycle();
        #2;
        chk("b_vld_hold", 64'(b_valid), 64'd1);
        chk("b_resp_hold", 64'(b_resp), 64'(resp));
        b_ready = 1'b1;
        next_cycle();
        b_ready = 1'b0;
        #2;
        chk("done", 64'(recv_done), 64'(fin));
        chk("aw_rdy_after_b", 64'(aw_ready), 64'(!fin));
        if (fin) begin
            next_cycle();
            #2;
            chk("done_one_cycle", 64'(recv_done), 64'd0);
            chk("idle_after_done", 64'(recv_req_ready), 64'd1);
            next_cycle();
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        recv_req_valid = 1'b0;
        recv_len       = '0;
        aw_valid       = 1'b0;
        aw_id          = '0;
        aw_addr        = '0;
        aw_len         = '0;
        w_valid        = 1'b1;
        w_data         = '1;
        w_strb         = '1;
        w_last         = 1'b0;
        b_ready        = 1'b0;
        data_ready     = 1'b1;
        #2;
        chk("rst_req_rdy", 64'(recv_req_ready), 64'd0);
        chk("rst_data_vld", 64'(data_valid), 64'd0);
        chk("rst_data", data_o[63:0], 64'd0);
        chk("rst_strb", data_strb, 64'd0);
        chk("rst_done", 64'(recv_done), 64'd0);
        w_valid = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        #2;
        chk("post_rst_req_rdy", 64'(recv_req_ready), 64'd1);
        next_cycle();

        // Two 64-beat bursts covering a 128-beat transfer
        start_xfer(32'd128);
        burst(4'd1, 48'h1000, 8'd63, 64, 63, -1, 0, 2'b00, 1'b0);
        burst(4'd2, 48'h2000, 8'd63, 64, 63, -1, 0, 2'b00, 1'b1);

        // Single beat
        start_xfer(32'd1);
        burst(4'd3, 48'h4000, 8'd0, 1, 0, -1, 0, 2'b00, 1'b1);

        // Sink stall of 3 cycles on beat 2
        start_xfer(32'd4);
        burst(4'd4, 48'h8000, 8'd3, 4, 3, 2, 3, 2'b00, 1'b1);

        // Early w_last on beat 1 (second of four)
        start_xfer(32'd4);
        burst(4'd5, 48'h9000, 8'd3, 4, 1, -1, 0, 2'b10, 1'b1);

        // AW longer than remaining length
        start_xfer(32'd4);
        burst(4'd6, 48'hA000, 8'd7, 8, 7, -1, 0, 2'b10, 1'b1);

        // Zero-length transfer
        recv_req_valid = 1'b1;
        recv_len       = 32'd0;
        next_cycle();
        recv_req_valid = 1'b0;
        #2;
        chk("len0_done", 64'(recv_done), 64'd1);
        chk("len0_aw_rdy", 64'(aw_ready), 64'd0);
        next_cycle();
        #2;
        chk("len0_done_off", 64'(recv_done), 64'd0);
        chk("len0_idle", 64'(recv_req_ready), 64'd1);
        next_cycle();

        // Reset while in DATA, then a fresh transfer
        start_xfer(32'd2);
        aw_valid = 1'b1;
        aw_id    = 4'd7;
        aw_addr  = 48'h3000;
        aw_len   = 8'd1;
        next_cycle();
        aw_valid   = 1'b0;
        w_valid    = 1'b1;
        w_data     = '1;
        data_ready = 1'b1;
        next_cycle();
        rst_n = 1'b0;
        #2;
        chk("mid_rst_data_vld", 64'(data_valid), 64'd0);
        chk("mid_rst_w_rdy", 64'(w_ready), 64'd0);
        chk("mid_rst_data", data_o[63:0], 64'd0);
        chk("mid_rst_addr", 64'(data_addr), 64'd0);
        chk("mid_rst_b_vld", 64'(b_valid), 64'd0);
        chk("mid_rst_req_rdy", 64'(recv_req_ready), 64'd0);
        next_cycle();
        rst_n   = 1'b1;
        w_valid = 1'b0;
        #2;
        chk("after_rst_idle", 64'(recv_req_ready), 64'd1);
        chk("after_rst_done", 64'(recv_done), 64'd0);
        next_cycle();
        start_xfer(32'd2);
        burst(4'd8, 48'h3000, 8'd1, 2, 1, -1, 0, 2'b00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
